// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the chained BCD counter and its digit cells.
package bcd_pkg;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic bcd_t bcd_min(input bcd_t a, input bcd_t b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter chain: computes the next digit value and the
// carry/borrow into the next more significant digit.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] cur,
  input  logic [BCD_W-1:0] max,
  input  logic             dir,
  input  logic             step_in,
  output logic [BCD_W-1:0] nxt,
  output logic             step_out,
  output logic             at_end
);

  always_comb begin
    // ">=" keeps an out-of-range digit from counting past its maximum
    at_end   = (dir == DIR_UP) ? (cur >= max) : (cur == '0);
    nxt      = cur;
    step_out = 1'b0;
    if (step_in) begin
      if (at_end) begin
        nxt      = (dir == DIR_UP) ? '0 : max;
        step_out = 1'b1;
      end else begin
        nxt = (dir == DIR_UP) ? (cur + 1'b1) : (cur - 1'b1);
      end
    end
  end

endmodule

// File: rtl/bcd_chain_counter.sv
// Multi-digit up/down BCD counter with per-digit modulus, load, clear and wrap/saturate.
// Define BCD_CHAIN_TICK_EDGE_EN to count falling edges of a level tick_in instead of strobes.
module bcd_chain_counter
  import bcd_pkg::*;
#(
  parameter int               DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] DIGIT_MAX = 16'h5959,
  parameter bit               WRAP      = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick_in,
  input  logic                en,
  input  logic                dir,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                clear,
  output logic [4*DIGITS-1:0] value,
  output logic                zero,
  output logic                wrap_pulse,
  output logic                done
);

  logic [4*DIGITS-1:0] r_value;
  logic                r_wrap;
  logic                r_done;

  logic [DIGITS:0]     w_step;
  logic [DIGITS-1:0]   w_at_end;
  logic [4*DIGITS-1:0] w_nxt;
  logic [4*DIGITS-1:0] w_clamped;
  logic                w_strobe;
  logic                w_acc;
  logic                w_overflow;
  logic                w_hold;

  assign w_step[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .cur      (r_value[g*BCD_W +: BCD_W]),
      .max      (DIGIT_MAX[g*BCD_W +: BCD_W]),
      .dir      (dir),
      .step_in  (w_step[g]),
      .nxt      (w_nxt[g*BCD_W +: BCD_W]),
      .step_out (w_step[g+1]),
      .at_end   (w_at_end[g])
    );
    assign w_clamped[g*BCD_W +: BCD_W] =
      bcd_min(load_value[g*BCD_W +: BCD_W], DIGIT_MAX[g*BCD_W +: BCD_W]);
  end

`ifdef BCD_CHAIN_TICK_EDGE_EN
  logic r_tick_q;

  // Edge register runs every cycle so en/load/clear never hide an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tick_q <= 1'b0;
    else          r_tick_q <= tick_in;
  end

  assign w_strobe = r_tick_q & ~tick_in;
`else
  assign w_strobe = tick_in;
`endif

  assign w_acc      = w_strobe & en;
  assign w_overflow = w_step[DIGITS];
  assign w_hold     = (WRAP == 1'b0) && (&w_at_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      if (load) begin
        r_value <= w_clamped;
      end else if (clear) begin
        r_value <= '0;
      end else if (w_acc) begin
        if (!w_hold) r_value <= w_nxt;
        r_wrap <= w_overflow && (WRAP == 1'b1);
        r_done <= (dir == DIR_DOWN) && !w_overflow && (w_nxt == '0);
      end
    end
  end

  assign value      = r_value;
  assign zero       = (r_value == '0);
  assign wrap_pulse = r_wrap;
  assign done       = r_done;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed bench for bcd_chain_counter: a wrapping and a saturating instance share stimulus
// and are checked every cycle against a mixed-radix integer model.
module tb_bcd_chain_counter;

  localparam logic [15:0] DMAX = 16'h5959;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        en = 1'b1;
  logic        dir = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic        clear = 1'b0;

  logic [15:0] value_w, value_s;
  logic        zero_w, zero_s, wp_w, wp_s, done_w, done_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_chain_counter #(.DIGITS(4), .DIGIT_MAX(DMAX), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .en(en), .dir(dir),
    .load(load), .load_value(load_value), .clear(clear),
    .value(value_w), .zero(zero_w), .wrap_pulse(wp_w), .done(done_w)
  );

  bcd_chain_counter #(.DIGITS(4), .DIGIT_MAX(DMAX), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .en(en), .dir(dir),
    .load(load), .load_value(load_value), .clear(clear),
    .value(value_s), .zero(zero_s), .wrap_pulse(wp_s), .done(done_s)
  );

  // ---------------- model: value kept as a plain integer in mixed radix ----------------
  function automatic int radix(input int i);
    logic [15:0] dm;
    dm = DMAX;
    return int'(dm[i*4 +: 4]) + 1;
  endfunction

  function automatic int weight(input int i);
    int w;
    w = 1;
    for (int j = 0; j < i; j++) w = w * radix(j);
    return w;
  endfunction

  function automatic int clamp_int(input logic [15:0] lv);
    int s, nib, mx;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      nib = int'(lv[i*4 +: 4]);
      mx  = radix(i) - 1;
      s   = s + ((nib < mx) ? nib : mx) * weight(i);
    end
    return s;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / weight(i)) % radix(i));
    return r;
  endfunction

  int m_v  [2] = '{0, 0};
  bit m_wp [2] = '{0, 0};
  bit m_dn [2] = '{0, 0};
  bit m_tq = 1'b0;

  function automatic bit m_acc();
`ifdef BCD_CHAIN_TICK_EDGE_EN
    return m_tq && !tick_in && en;
`else
    return tick_in && en;
`endif
  endfunction

  function automatic int nxt_v(input int v, input bit w);
    int top;
    top = weight(4) - 1;
    if (load)     return clamp_int(load_value);
    if (clear)    return 0;
    if (!m_acc()) return v;
    if (dir == 1'b0) return (v == top) ? (w ? 0 : v) : v + 1;
    return (v == 0) ? (w ? top : 0) : v - 1;
  endfunction

  function automatic bit nxt_wp(input int v, input bit w);
    if (load || clear || !m_acc() || !w) return 1'b0;
    return (dir == 1'b0) ? (v == weight(4) - 1) : (v == 0);
  endfunction

  function automatic bit nxt_dn(input int v);
    return !load && !clear && m_acc() && dir && (v == 1);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_v[k]  <= 0;
        m_wp[k] <= 1'b0;
        m_dn[k] <= 1'b0;
      end
      m_tq <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_v[k]  <= nxt_v(m_v[k], k == 0);
        m_wp[k] <= nxt_wp(m_v[k], k == 0);
        m_dn[k] <= nxt_dn(m_v[k]);
      end
      m_tq <= tick_in;
    end
  end

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("wrap.value", value_w, to_bcd(m_v[0]));
    check("wrap.zero",  16'(zero_w), 16'(m_v[0] == 0));
    check("wrap.wrap_pulse", 16'(wp_w), 16'(m_wp[0]));
    check("wrap.done",  16'(done_w), 16'(m_dn[0]));
    check("sat.value",  value_s, to_bcd(m_v[1]));
    check("sat.zero",   16'(zero_s), 16'(m_v[1] == 0));
    check("sat.wrap_pulse", 16'(wp_s), 16'(m_wp[1]));
    check("sat.done",   16'(done_s), 16'(m_dn[1]));
  end

  // ---------------- stimulus helpers: each ends on the negedge where the result is visible ----
  task automatic do_tick();
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) tick_in = 1'b0;
`ifdef BCD_CHAIN_TICK_EDGE_EN
    @(negedge clk);
`endif
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk) begin load = 1'b1; load_value = v; end
    @(negedge clk) load = 1'b0;
  endtask

  task automatic load_with_tick(input logic [15:0] v);
`ifdef BCD_CHAIN_TICK_EDGE_EN
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) begin tick_in = 1'b0; load = 1'b1; load_value = v; end
    @(negedge clk) load = 1'b0;
`else
    @(negedge clk) begin tick_in = 1'b1; load = 1'b1; load_value = v; end
    @(negedge clk) begin tick_in = 1'b0; load = 1'b0; end
`endif
  endtask

  task automatic square_period(input logic en_v);
    en = en_v;
    tick_in = 1'b1;
    repeat (4) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset.value", value_w, 16'h0000);
    check("reset.zero", 16'(zero_w), 16'h0001);
    check("reset.wrap_pulse", 16'(wp_w), 16'h0000);
    check("reset.done", 16'(done_w), 16'h0000);
    @(negedge clk) reset_n = 1'b1;

    // Up through all-max: wrap vs saturate
    dir = 1'b0;
    do_load(16'h5958);
    do_tick();
    check("up.5959", value_w, 16'h5959);
    do_tick();
    check("up.wrap_value", value_w, 16'h0000);
    check("up.wrap_pulse", 16'(wp_w), 16'h0001);
    check("up.sat_hold", value_s, 16'h5959);
    check("up.sat_no_pulse", 16'(wp_s), 16'h0000);
    @(negedge clk);
    check("up.pulse_one_cycle", 16'(wp_w), 16'h0000);

    // Down: borrow, done, wrap from zero
    dir = 1'b1;
    do_load(16'h0100);
    do_tick();
    check("down.borrow", value_w, 16'h0059);
    do_load(16'h0001);
    do_tick();
    check("down.zero_value", value_w, 16'h0000);
    check("down.done", 16'(done_w), 16'h0001);
    check("down.no_wrap", 16'(wp_w), 16'h0000);
    do_tick();
    check("down.wrap_value", value_w, 16'h5959);
    check("down.wrap_pulse", 16'(wp_w), 16'h0001);
    check("down.wrap_no_done", 16'(done_w), 16'h0000);
    check("sat.hold_zero", value_s, 16'h0000);
    check("sat.no_repeat_done", 16'(done_s), 16'h0000);
    check("sat.zero_flag", 16'(zero_s), 16'h0001);
    do_tick();
    check("sat.still_zero", value_s, 16'h0000);
    check("sat.no_wrap", 16'(wp_s), 16'h0000);

    // Clamp on load, load beats tick, clear
    do_load(16'hF97A);
    check("load.clamp", value_w, 16'h5959);
    load_with_tick(16'h1234);
    check("load.beats_tick", value_w, 16'h1234);
    @(negedge clk);
    check("load.tick_dropped", value_s, 16'h1234);
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    check("clear.value", value_w, 16'h0000);

    // Continuous counting and en gating
    dir = 1'b0;
`ifdef BCD_CHAIN_TICK_EDGE_EN
    repeat (3) square_period(1'b1);
    square_period(1'b0);
    repeat (2) square_period(1'b1);
    check("edge.count", value_w, 16'h0005);
    dir = 1'b1;
    repeat (2) square_period(1'b1);
    check("edge.down", value_w, 16'h0003);
`else
    @(negedge clk) tick_in = 1'b1;
    repeat (15) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("level.count", value_w, 16'h0015);
    en = 1'b1;
    dir = 1'b1;
    repeat (3) @(negedge clk);
    tick_in = 1'b0;
    check("level.dir_change", value_w, 16'h0012);
`endif

    // Mid-count asynchronous reset, then resume
    dir = 1'b0;
    en = 1'b1;
    do_load(16'h0123);
    do_tick();
    do_tick();
    #2 reset_n = 1'b0;
    #1;
    check("areset.value", value_w, 16'h0000);
    check("areset.zero", 16'(zero_w), 16'h0001);
    check("areset.sat_value", value_s, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) do_tick();
    check("resume.count", value_w, 16'h0003);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised multi-digit BCD counter: up or down, loadable, with a per-digit modulus (e.g. mm:ss, hh:mm, 00–99 stopwatch) and saturate or wrap at the ends. Generalises the fixed 60/100 up counters and the 60 down counter into one block. It sits behind the clock-divider tick chain and drives the FND/display decoders and the timer/alarm control FSMs.

## Interface
- DIGITS, 4, number of BCD digits (1–8); digit 0 is least significant.
- DIGIT_MAX, 16'h5959, packed 4*DIGITS vector; nibble i is the maximum value of digit i (1–9).
- WRAP, 1, 1: wrap at both ends; 0: saturate at all-zero (down) and all-max (up).
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick_in  in  1  count strobe; see Configuration for pulse or level interpretation.
- en  in  1  1: accept ticks; 0: ticks ignored.
- dir  in  1  0: count up; 1: count down.
- load  in  1  synchronous load of load_value.
- load_value  in  4*DIGITS  BCD load value.
- clear  in  1  synchronous clear to zero.
- value  out  4*DIGITS  current BCD count (registered).
- zero  out  1  level: value is all-zero.
- wrap_pulse  out  1  one-cycle pulse: count wrapped (up: all-max to 0; down: 0 to all-max).
- done  out  1  one-cycle pulse: a down tick made value reach 0.

## Operation
- Per-cycle priority: reset_n low > load > clear > accepted tick > hold.
- Load: each nibble is clamped to min(load_value[i], DIGIT_MAX[i]); nibbles 10–15 are clamped too. Load generates no wrap_pulse and no done.
- Clear: value = 0; no pulses.
- Accepted tick = tick strobe & en.
- Up: digit 0 increments. A digit at its max becomes 0 and carries into the next digit. If every digit is at max: WRAP=1 gives all-zero plus wrap_pulse; WRAP=0 holds the value with no pulse.
- Down: digit 0 decrements. A digit at 0 becomes its max and borrows from the next digit. If value is all-zero: WRAP=1 gives all-max plus wrap_pulse; WRAP=0 holds the value, with no pulse and no repeated done.
- done fires when a down tick takes value from nonzero to 0. With WRAP=1, a down tick from 0 wraps to all-max and gives wrap_pulse, not done.
- zero is decoded from registered value, so it is glitch-free.
- dir may change on any cycle; the change takes effect on the next accepted tick.

## Timing
- Reset values: value = 0, zero = 1, wrap_pulse = 0, done = 0, edge-detector state = 0.
- Latency: accepted tick in cycle N → value, wrap_pulse and done updated at the edge ending cycle N. Pulses are high for exactly cycle N+1.
- Carry/borrow ripples combinationally across all DIGITS within one cycle; there is no multi-cycle carry.
- Load or clear coinciding with a tick: the tick is dropped, with no pulse.
- Back-to-back ticks every cycle must count correctly.
- If reset_n is asserted mid-count, all state clears immediately. The first post-reset tick_in edge is measured against the reset edge state of 0.

## Configuration
- BCD_CHAIN_TICK_EDGE_EN defined: tick_in is a level clock, such as a divider's square output. The strobe is its falling edge, detected by one register tick_q: strobe = tick_q & ~tick_in. tick_q updates every cycle regardless of en, load or clear.
- BCD_CHAIN_TICK_EDGE_EN undefined: tick_in is already a one-cycle strobe and is used directly. There is no edge register, and a tick_in held high counts every cycle.

## Structure
- Shared package bcd_pkg: localparam BCD_W = 4, a typedef for the BCD nibble, and the DIR_UP/DIR_DOWN constants.
- Sub-module bcd_digit_cell: one digit with inputs cur, max, dir, step_in and outputs nxt, step_out (carry/borrow) and at_end.
  - Instantiate it DIGITS times in a generate loop.
  - The top level owns the registers, priority logic, clamping, pulses and the edge detector.

## Test plan
- DIGITS=4, DIGIT_MAX=16'h5959, WRAP=1, up: load 16'h5958, 2 ticks.
  - Value goes 5959 then 0000.
  - wrap_pulse is high for one cycle after the second tick.
- Same configuration, down: load 16'h0100, 1 tick → 0059. Load 16'h0001, 1 tick → 0000 with done pulse; one more tick → 5959 with wrap_pulse and no done.
- WRAP=0, down from 0001: 3 ticks.
  - Value stays at 0000.
  - done pulses once only; wrap_pulse never fires; zero = 1.
- Load 16'hF97A with DIGIT_MAX 16'h5959: value = 5959. Load and tick asserted in the same cycle with load_value 16'h1234: value = 1234, tick ignored.
- With BCD_CHAIN_TICK_EDGE_EN defined: square wave on tick_in (4 high / 4 low cycles), en toggled low for one period.
  - One increment per falling edge.
  - No increment during the en=0 period.
  - Each increment is visible one cycle after tick_in is first sampled low.
- Mid-count reset_n pulse: all outputs return to their reset values asynchronously. Counting resumes correctly from 0000 after release.
